stall_ctrl: RTL and testbench
=============================

Name: stall_ctrl

Overview:
- Hazard/stall controller for the 5-stage MIPS pipeline; sits directly downstream of the per-instruction Tuse/Tnew decoder.
- Consumes the D-stage need/Tuse/Tnew values and tracks destination register plus remaining Tnew for the E and M stages.
- Tracks the mult/div unit busy window.
- Produces the pipeline stall (freeze PC/IF-ID, bubble into ID-EX) and the E/M hazard records used by the forwarding muxes.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu issues into E
DIV_CYCLES, 10, busy cycles after a div/divu issues into E

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
D_need_rs  input  1  D-stage instruction reads rs (from decoder)
D_need_rt  input  1  D-stage instruction reads rt
D_Tuse_rs  input  3  cycles until rs is consumed
D_Tuse_rt  input  3  cycles until rt is consumed
D_Tnew  input  3  cycles from E-stage entry until result is available
D_rs  input  5  rs field
D_rt  input  5  rt field
D_A3  input  5  destination register (0 = no write)
D_md_start  input  1  D-stage instruction is mult/multu/div/divu
D_md_div  input  1  with D_md_start: 1 = div/divu, 0 = mult/multu
D_md_use  input  1  D-stage instruction uses HI/LO (mult, div, mfhi, mflo, mthi, mtlo)
stall  output  1  combinational; 1 = hold PC and IF/ID, insert bubble into ID/EX
E_A3  output  5  E-stage destination register
E_Tnew  output  3  E-stage remaining Tnew
M_A3  output  5  M-stage destination register
M_Tnew  output  3  M-stage remaining Tnew
md_busy  output  1  mult/div unit busy (md_cnt != 0)

Behaviour:
Reset:
- On a clk edge with reset=1: E_A3, E_Tnew, M_A3, M_Tnew, md_cnt all 0; md_busy=0.
- reset overrides all other updates.

Stall (combinational, evaluated every cycle):
- stall_rs = D_need_rs && D_rs!=0 && ((D_rs==E_A3 && E_Tnew>D_Tuse_rs) || (D_rs==M_A3 && M_Tnew>D_Tuse_rs)).
- stall_rt is the same with rt/Tuse_rt.
- stall_md = D_md_use && md_busy.
- stall = stall_rs | stall_rt | stall_md.
- All comparisons are 3-bit unsigned.
- Register 0 never causes a stall. The W stage is never a stall source; GRF internal forwarding covers it.

Record pipeline (each clk edge, reset=0):
- If stall=1: E_A3 <= 0 and E_Tnew <= 0 (bubble).
- If stall=0: E_A3 <= D_A3 and E_Tnew <= D_Tnew.
- Every edge: M_A3 <= E_A3; M_Tnew <= (E_Tnew==0) ? 0 : E_Tnew-1 (saturating, never wraps).
- No freeze input; E/M always advance.

Mult/div counter md_cnt (width ceil(log2(max(MULT,DIV)+1))):
- If D_md_start && !stall: load DIV_CYCLES if D_md_div, else MULT_CYCLES. Load has priority over decrement.
- Else if md_cnt!=0: decrement.
- Else: hold at 0.
- md_busy = (md_cnt!=0), combinational from the register.
- Input contract: D_md_start implies D_md_use. A second mult/div therefore stalls until the previous one finishes.

Latency:
- stall has zero-cycle latency from its inputs.
- An instruction's record appears in E one edge after issue and in M two edges after issue.

Test Plan:
- lw $1 in E (E_A3=1, E_Tnew=2), D add rs=1 (Tuse_rs=1): stall=1. Next edge: E bubble (E_A3=0), M_A3=1, M_Tnew=1, stall=0.
- add $2 in E (E_Tnew=1), D beq rs=2 (Tuse=0): stall=1 for exactly 1 cycle. Next cycle M_Tnew=0, stall=0.
- D sw rt=3 (Tuse_rt=2), lw $3 in E (E_Tnew=2): stall=0 (2>2 false). D_rs=0 with E_A3=0, E_Tnew=2: stall=0.
- mult issues (D_md_start=1, D_md_div=0, stall=0); next cycle D mflo: stall=1 for 5 cycles (md_cnt 5..1), then stall=0. Repeat with div: 10 cycles.
- div issued, then div in D while md_cnt=3: stall=1, no reload until md_cnt=0. Reload to 10 on the issue edge.
- reset=1 mid-division (md_cnt=7, E_A3=5, E_Tnew=2): after the edge all records and md_cnt are 0, md_busy=0, and stall depends only on D_* inputs (0 for nonzero-free records).

Source files
------------

// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: Tuse/Tnew stall detection,
// E/M destination-register records and the mult/div busy window.
module stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       D_need_rs,
   input  logic       D_need_rt,
   input  logic [2:0] D_Tuse_rs,
   input  logic [2:0] D_Tuse_rt,
   input  logic [2:0] D_Tnew,
   input  logic [4:0] D_rs,
   input  logic [4:0] D_rt,
   input  logic [4:0] D_A3,
   input  logic       D_md_start,
   input  logic       D_md_div,
   input  logic       D_md_use,
   output logic       stall,
   output logic [4:0] E_A3,
   output logic [2:0] E_Tnew,
   output logic [4:0] M_A3,
   output logic [2:0] M_Tnew,
   output logic       md_busy
);

   localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W  = $clog2(MD_MAX + 1);

   logic [4:0]       r_E_A3;
   logic [2:0]       r_E_Tnew;
   logic [4:0]       r_M_A3;
   logic [2:0]       r_M_Tnew;
   logic [CNT_W-1:0] r_md_cnt;

   logic w_stall_rs;
   logic w_stall_rt;
   logic w_stall_md;
   logic w_stall;
   logic w_md_busy;

   // Remaining Tnew counts down one per stage and floors at zero.
   function automatic logic [2:0] sat_dec(input logic [2:0] t);
      return (t == 3'd0) ? 3'd0 : t - 3'd1;
   endfunction

   always_comb begin
      w_md_busy  = (r_md_cnt != '0);
      w_stall_rs = D_need_rs && (D_rs != 5'd0) &&
                   (((D_rs == r_E_A3) && (r_E_Tnew > D_Tuse_rs)) ||
                    ((D_rs == r_M_A3) && (r_M_Tnew > D_Tuse_rs)));
      w_stall_rt = D_need_rt && (D_rt != 5'd0) &&
                   (((D_rt == r_E_A3) && (r_E_Tnew > D_Tuse_rt)) ||
                    ((D_rt == r_M_A3) && (r_M_Tnew > D_Tuse_rt)));
      w_stall_md = D_md_use && w_md_busy;
      w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_E_A3   <= 5'd0;
         r_E_Tnew <= 3'd0;
         r_M_A3   <= 5'd0;
         r_M_Tnew <= 3'd0;
         r_md_cnt <= '0;
      end else begin
         // A stalled D instruction is replaced by a bubble entering E.
         if (w_stall) begin
            r_E_A3   <= 5'd0;
            r_E_Tnew <= 3'd0;
         end else begin
            r_E_A3   <= D_A3;
            r_E_Tnew <= D_Tnew;
         end
         r_M_A3   <= r_E_A3;
         r_M_Tnew <= sat_dec(r_E_Tnew);
         if (D_md_start && !w_stall) begin
            r_md_cnt <= D_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - CNT_W'(1);
         end
      end
   end

   assign stall   = w_stall;
   assign E_A3    = r_E_A3;
   assign E_Tnew  = r_E_Tnew;
   assign M_A3    = r_M_A3;
   assign M_Tnew  = r_M_Tnew;
   assign md_busy = w_md_busy;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: reset, data hazards on rs/rt, mult/div busy window,
// back-to-back mult/div and mid-operation reset.
module tb_stall_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       D_need_rs, D_need_rt, D_md_start, D_md_div, D_md_use;
   logic [2:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
   logic [4:0] D_rs, D_rt, D_A3;
   logic       stall, md_busy;
   logic [4:0] E_A3, M_A3;
   logic [2:0] E_Tnew, M_Tnew;

   int n_checks = 0;
   int n_errors = 0;

   stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset),
      .D_need_rs(D_need_rs), .D_need_rt(D_need_rt),
      .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_Tnew(D_Tnew),
      .D_rs(D_rs), .D_rt(D_rt), .D_A3(D_A3),
      .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
      .stall(stall), .E_A3(E_A3), .E_Tnew(E_Tnew), .M_A3(M_A3), .M_Tnew(M_Tnew),
      .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_d();
      D_need_rs = 0; D_need_rt = 0; D_Tuse_rs = 0; D_Tuse_rt = 0; D_Tnew = 0;
      D_rs = 0; D_rt = 0; D_A3 = 0; D_md_start = 0; D_md_div = 0; D_md_use = 0;
      #1;
   endtask

   task automatic issue(input logic [4:0] a3, input logic [2:0] tnew);
      clear_d();
      D_A3 = a3; D_Tnew = tnew;
      tick();
   endtask

   task automatic flush();
      clear_d();
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_reset();
      clear_d();
      reset = 1;
      tick(); tick();
      n_checks++;
      if ({E_A3, E_Tnew, M_A3, M_Tnew, md_busy, stall} !== 17'd0) begin
         n_errors++;
         $display("FAIL reset_state got E=%0d/%0d M=%0d/%0d busy=%0b stall=%0b exp all 0",
                  E_A3, E_Tnew, M_A3, M_Tnew, md_busy, stall);
      end
      reset = 0;
   endtask

   task automatic test_load_use();
      flush();
      issue(5'd1, 3'd2);
      n_checks++;
      if (E_A3 !== 5'd1 || E_Tnew !== 3'd2) begin
         n_errors++; $display("FAIL e_record got %0d/%0d exp 1/2", E_A3, E_Tnew);
      end
      D_need_rs = 1; D_rs = 5'd1; D_Tuse_rs = 3'd1; D_A3 = 5'd4; D_Tnew = 3'd1; #1;
      n_checks++;
      if (stall !== 1'b1) begin n_errors++; $display("FAIL lw_use_stall got %0b exp 1", stall); end
      tick();
      n_checks++;
      if (E_A3 !== 5'd0 || E_Tnew !== 3'd0 || M_A3 !== 5'd1 || M_Tnew !== 3'd1 || stall !== 1'b0) begin
         n_errors++;
         $display("FAIL lw_use_after got E=%0d/%0d M=%0d/%0d stall=%0b exp E=0/0 M=1/1 stall=0",
                  E_A3, E_Tnew, M_A3, M_Tnew, stall);
      end
      tick();
      n_checks++;
      if (E_A3 !== 5'd4 || E_Tnew !== 3'd1 || M_A3 !== 5'd0) begin
         n_errors++; $display("FAIL lw_use_issue got E=%0d/%0d M=%0d exp E=4/1 M=0", E_A3, E_Tnew, M_A3);
      end
   endtask

   task automatic test_branch();
      flush();
      issue(5'd2, 3'd1);
      D_need_rs = 1; D_rs = 5'd2; D_Tuse_rs = 3'd0; #1;
      n_checks++;
      if (stall !== 1'b1) begin n_errors++; $display("FAIL beq_stall got %0b exp 1", stall); end
      tick();
      n_checks++;
      if (M_A3 !== 5'd2 || M_Tnew !== 3'd0 || stall !== 1'b0) begin
         n_errors++; $display("FAIL beq_release got M=%0d/%0d stall=%0b exp M=2/0 stall=0", M_A3, M_Tnew, stall);
      end
      // rt path through the M stage: M_Tnew=1 > Tuse_rt=0
      flush();
      issue(5'd7, 3'd2);
      clear_d(); tick();
      D_need_rt = 1; D_rt = 5'd7; D_Tuse_rt = 3'd0; #1;
      n_checks++;
      if (stall !== 1'b1 || M_Tnew !== 3'd1) begin
         n_errors++; $display("FAIL rt_m_stall got stall=%0b M_Tnew=%0d exp 1/1", stall, M_Tnew);
      end
      D_need_rt = 0; #1;
      n_checks++;
      if (stall !== 1'b0) begin n_errors++; $display("FAIL rt_not_needed got %0b exp 0", stall); end
   endtask

   task automatic test_no_stall();
      flush();
      issue(5'd3, 3'd2);
      D_need_rt = 1; D_rt = 5'd3; D_Tuse_rt = 3'd2; #1;
      n_checks++;
      if (stall !== 1'b0) begin n_errors++; $display("FAIL sw_equal_tuse got %0b exp 0", stall); end
      flush();
      issue(5'd0, 3'd2);
      D_need_rs = 1; D_rs = 5'd0; D_Tuse_rs = 3'd0; #1;
      n_checks++;
      if (stall !== 1'b0 || E_Tnew !== 3'd2) begin
         n_errors++; $display("FAIL reg_zero got stall=%0b E_Tnew=%0d exp 0/2", stall, E_Tnew);
      end
   endtask

   task automatic test_md_window(input logic is_div, input int exp_cycles);
      int cnt;
      flush();
      D_md_start = 1; D_md_use = 1; D_md_div = is_div; #1;
      n_checks++;
      if (stall !== 1'b0) begin n_errors++; $display("FAIL md_issue_stall got %0b exp 0", stall); end
      tick();
      clear_d();
      D_md_use = 1; #1;
      cnt = 0;
      for (int i = 0; i < 30 && stall === 1'b1; i++) begin
         cnt++;
         tick();
      end
      n_checks++;
      if (cnt != exp_cycles || md_busy !== 1'b0) begin
         n_errors++; $display("FAIL md_window got %0d busy=%0b exp %0d busy=0", cnt, md_busy, exp_cycles);
      end
   endtask

   task automatic test_back_to_back();
      int cnt;
      flush();
      D_md_start = 1; D_md_use = 1; D_md_div = 1; #1;
      tick();
      for (int i = 0; i < 7; i++) tick();
      n_checks++;
      if (stall !== 1'b1 || md_busy !== 1'b1) begin
         n_errors++; $display("FAIL b2b_cnt3 got stall=%0b busy=%0b exp 1/1", stall, md_busy);
      end
      cnt = 0;
      for (int i = 0; i < 30 && stall === 1'b1; i++) begin
         cnt++;
         tick();
      end
      n_checks++;
      if (cnt != 3) begin n_errors++; $display("FAIL b2b_remaining got %0d exp 3", cnt); end
      tick();
      clear_d();
      cnt = 0;
      for (int i = 0; i < 30 && md_busy === 1'b1; i++) begin
         cnt++;
         tick();
      end
      n_checks++;
      if (cnt != 10) begin n_errors++; $display("FAIL b2b_reload got %0d exp 10", cnt); end
   endtask

   task automatic test_reset_mid_div();
      flush();
      D_md_start = 1; D_md_use = 1; D_md_div = 1; #1;
      tick();
      issue(5'd0, 3'd0);
      issue(5'd0, 3'd0);
      issue(5'd5, 3'd2);
      n_checks++;
      if (E_A3 !== 5'd5 || E_Tnew !== 3'd2 || md_busy !== 1'b1) begin
         n_errors++; $display("FAIL pre_reset got E=%0d/%0d busy=%0b exp 5/2/1", E_A3, E_Tnew, md_busy);
      end
      reset = 1;
      tick();
      reset = 0;
      D_md_use = 1; D_need_rs = 1; D_rs = 5'd5; D_Tuse_rs = 3'd0; #1;
      n_checks++;
      if ({E_A3, E_Tnew, M_A3, M_Tnew, md_busy, stall} !== 17'd0) begin
         n_errors++;
         $display("FAIL reset_mid_div got E=%0d/%0d M=%0d/%0d busy=%0b stall=%0b exp all 0",
                  E_A3, E_Tnew, M_A3, M_Tnew, md_busy, stall);
      end
   endtask

   initial begin
      reset = 1;
      clear_d();
      test_reset();
      test_load_use();
      test_branch();
      test_no_stall();
      test_md_window(1'b0, 5);
      test_md_window(1'b1, 10);
      test_back_to_back();
      test_reset_mid_div();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
